// File: rtl/spi_pkg.sv
// Shared constants and types for the memory-mapped SPI master.
// Register offsets are byte offsets within the 256-byte window.
package spi_pkg;

    localparam logic [7:0] OFF_SCKDIV = 8'h00;
    localparam logic [7:0] OFF_CSID   = 8'h10;
    localparam logic [7:0] OFF_CSMODE = 8'h18;
    localparam logic [7:0] OFF_TXDATA = 8'h48;
    localparam logic [7:0] OFF_RXDATA = 8'h4c;

    localparam logic [1:0] CSMODE_AUTO = 2'd0;
    localparam logic [1:0] CSMODE_HOLD = 2'd2;
    localparam logic [1:0] CSMODE_OFF  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } spi_state_e;

endpackage

// File: rtl/spi_master_mmio_fifo.sv
// Synchronous FIFO with first-word fall-through head output.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W       = 8,
    parameter int LGDEPTH = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int DEPTH = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0] FULL_CNT = (LGDEPTH + 1)'(DEPTH);

    logic [W-1:0]       mem_q [DEPTH];
    logic [LGDEPTH-1:0] wptr_q, wptr_d;
    logic [LGDEPTH-1:0] rptr_q, rptr_d;
    logic [LGDEPTH:0]   cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign head  = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            wptr_d = wptr_q + LGDEPTH'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + LGDEPTH'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (LGDEPTH + 1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (LGDEPTH + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/spi_master_mmio.sv
// Memory-mapped SPI master (mode 0) with programmable SCK divider,
// TX/RX FIFOs and chip-select modes; responds in the request cycle.
module spi_master_mmio
    import spi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h10024000,
    parameter int          NCS          = 1,
    parameter int          FIFO_LGDEPTH = 3,
    parameter int          DIV_W        = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rq_en,
    input  logic [31:0]     rq_addr,
    input  logic            rq_iswrite,
    input  logic [31:0]     rq_data,
    output logic            rq_hit,
    output logic            rs_en,
    output logic [31:0]     rs_data,
    output logic            spi_clk,
    output logic            spi_mosi,
    input  logic            spi_miso,
    output logic [NCS-1:0]  spi_csn
);

    localparam int CSID_W = (NCS > 1) ? $clog2(NCS) : 1;
    localparam logic [CSID_W-1:0] CSID_MASK = (NCS > 1) ? '1 : '0;

    logic [DIV_W-1:0]  sckdiv_q, sckdiv_d;
    logic [CSID_W-1:0] csid_q, csid_d;
    logic [1:0]        csmode_q, csmode_d;
    logic              rx_ovf_q, rx_ovf_d;

    spi_state_e        state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        tx_sh_q, tx_sh_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic              spi_clk_q, spi_clk_d;
    logic              spi_mosi_q, spi_mosi_d;
    logic [NCS-1:0]    spi_csn_q, spi_csn_d;

    logic [7:0] off;
    logic       in_win;
    logic       sel_sckdiv, sel_csid, sel_csmode, sel_tx, sel_rx;
    logic       wr, rd;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic       terminal, cs_act;
    logic       unused_ok;

    assign unused_ok = ^rq_data;

    assign off    = rq_addr[7:0];
    assign in_win = (rq_addr[31:8] == BASE_ADDR[31:8]);

    always_comb begin
        sel_sckdiv = in_win && (off == OFF_SCKDIV);
        sel_csid   = in_win && (off == OFF_CSID);
        sel_csmode = in_win && (off == OFF_CSMODE);
        sel_tx     = in_win && (off == OFF_TXDATA);
        sel_rx     = in_win && (off == OFF_RXDATA);
    end

    assign rq_hit = sel_sckdiv | sel_csid | sel_csmode | sel_tx | sel_rx;
    assign rs_en  = rq_en && rq_hit;
    assign wr     = rs_en && rq_iswrite;
    assign rd     = rs_en && !rq_iswrite;

    always_comb begin
        rs_data = '0;
        if (rd) begin
            unique case (1'b1)
                sel_sckdiv: rs_data = 32'(sckdiv_q);
                sel_csid:   rs_data = 32'(csid_q);
                sel_csmode: rs_data = {30'b0, csmode_q};
                sel_tx:     rs_data = {tx_full, 31'b0};
                sel_rx:     rs_data = {rx_empty, rx_ovf_q, 22'b0,
                                       rx_empty ? 8'h00 : rx_head};
                default:    rs_data = '0;
            endcase
        end
    end

    // A write that finds the FIFO full is dropped even if the shifter pops.
    assign tx_push = wr && sel_tx && !tx_full;
    assign rx_pop  = rd && sel_rx && !rx_empty;

    sync_fifo #(.W(8), .LGDEPTH(FIFO_LGDEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .din   (rq_data[7:0]),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .head  (tx_head)
    );

    sync_fifo #(.W(8), .LGDEPTH(FIFO_LGDEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .din   (rx_sh_q),
        .pop   (rx_pop),
        .full  (rx_full),
        .empty (rx_empty),
        .head  (rx_head)
    );

    always_comb begin
        sckdiv_d = sckdiv_q;
        csid_d   = csid_q;
        csmode_d = csmode_q;
        if (wr && sel_sckdiv) begin
            sckdiv_d = rq_data[DIV_W-1:0];
        end
        if (wr && sel_csid) begin
            csid_d = rq_data[CSID_W-1:0] & CSID_MASK;
        end
        if (wr && sel_csmode) begin
            csmode_d = rq_data[1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        spi_clk_d  = spi_clk_q;
        spi_mosi_d = spi_mosi_q;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        terminal   = (cnt_q == '0);
        unique case (state_q)
            ST_IDLE: begin
                spi_clk_d  = 1'b0;
                spi_mosi_d = 1'b0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    bitcnt_d   = 3'd7;
                    cnt_d      = sckdiv_q;
                    spi_mosi_d = tx_head[7];
                    state_d    = ST_LOW;
                end
            end
            ST_LOW: begin
                if (terminal) begin
                    rx_sh_d   = {rx_sh_q[6:0], spi_miso};
                    cnt_d     = sckdiv_q;
                    spi_clk_d = 1'b1;
                    state_d   = ST_HIGH;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_HIGH: begin
                if (terminal) begin
                    spi_clk_d = 1'b0;
                    if (bitcnt_q != 3'd0) begin
                        tx_sh_d    = {tx_sh_q[6:0], 1'b0};
                        spi_mosi_d = tx_sh_q[6];
                        bitcnt_d   = bitcnt_q - 3'd1;
                        cnt_d      = sckdiv_q;
                        state_d    = ST_LOW;
                    end else begin
                        rx_push    = 1'b1;
                        spi_mosi_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_ovf_d = rx_ovf_q;
        if (rd && sel_rx) begin
            rx_ovf_d = 1'b0;
        end
        if (rx_push && rx_full && !rx_pop) begin
            rx_ovf_d = 1'b1;
        end
    end

    always_comb begin
        unique case (csmode_q)
            CSMODE_HOLD: cs_act = 1'b1;
            CSMODE_OFF:  cs_act = 1'b0;
            default:     cs_act = (state_q != ST_IDLE) || !tx_empty;
        endcase
        for (int i = 0; i < NCS; i++) begin
            spi_csn_d[i] = !(cs_act && (csid_q == CSID_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sckdiv_q   <= '0;
            csid_q     <= '0;
            csmode_q   <= CSMODE_AUTO;
            rx_ovf_q   <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            spi_clk_q  <= 1'b0;
            spi_mosi_q <= 1'b0;
            spi_csn_q  <= '1;
        end else begin
            sckdiv_q   <= sckdiv_d;
            csid_q     <= csid_d;
            csmode_q   <= csmode_d;
            rx_ovf_q   <= rx_ovf_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            spi_clk_q  <= spi_clk_d;
            spi_mosi_q <= spi_mosi_d;
            spi_csn_q  <= spi_csn_d;
        end
    end

    assign spi_clk  = spi_clk_q;
    assign spi_mosi = spi_mosi_q;
    assign spi_csn  = spi_csn_q;

endmodule

// File: tb/tb_spi_master_mmio.sv
// Self-checking bench for spi_master_mmio: directed steps plus random
// bursts checked against a byte-level model of the SPI link.
module tb_spi_master_mmio;

    localparam logic [31:0] BASE = 32'h10024000;
    localparam logic [7:0] A_SCKDIV = 8'h00;
    localparam logic [7:0] A_CSID   = 8'h10;
    localparam logic [7:0] A_CSMODE = 8'h18;
    localparam logic [7:0] A_TX     = 8'h48;
    localparam logic [7:0] A_RX     = 8'h4c;

    logic        clk = 1'b0;
    logic        reset;
    logic        rq_en;
    logic [31:0] rq_addr;
    logic        rq_iswrite;
    logic [31:0] rq_data;
    logic        rq_hit;
    logic        rs_en;
    logic [31:0] rs_data;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic [1:0]  spi_csn;

    always #5 clk = ~clk;
    assign spi_miso = spi_mosi;

    spi_master_mmio #(
        .BASE_ADDR    (BASE),
        .NCS          (2),
        .FIFO_LGDEPTH (3),
        .DIV_W        (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rq_en      (rq_en),
        .rq_addr    (rq_addr),
        .rq_iswrite (rq_iswrite),
        .rq_data    (rq_data),
        .rq_hit     (rq_hit),
        .rs_en      (rs_en),
        .rs_data    (rs_data),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_csn    (spi_csn)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_bits[$];
    int   hi_runs[$];
    int   hi_cur = 0;
    int   cs0_low = 0;
    int   cs0_high = 0;
    int   cs1_low = 0;
    logic clk_prev = 1'b0;
    logic [7:0] wq[$];

    // Wire-level observer, sampled away from the active edge
    always @(negedge clk) begin
        if (spi_clk) begin
            hi_cur++;
        end else if (hi_cur > 0) begin
            hi_runs.push_back(hi_cur);
            hi_cur = 0;
        end
        if (spi_clk && !clk_prev) mon_bits.push_back(spi_mosi);
        clk_prev = spi_clk;
        if (!spi_csn[0]) cs0_low++;
        else cs0_high++;
        if (!spi_csn[1]) cs1_low++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_bits.delete();
        hi_runs.delete();
        hi_cur = 0;
        cs0_low = 0;
        cs0_high = 0;
        cs1_low = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        rq_addr = BASE | 32'(a);
        rq_iswrite = 1'b1;
        rq_data = d;
        rq_en = 1'b1;
        tick();
        rq_en = 1'b0;
        rq_iswrite = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        rq_addr = BASE | 32'(a);
        rq_iswrite = 1'b0;
        rq_en = 1'b1;
        #1;
        d = rs_data;
        tick();
        rq_en = 1'b0;
    endtask

    task automatic wait_done(input int idx);
        int k;
        k = 0;
        repeat (2) tick();
        while (spi_csn[idx] !== 1'b1 && k < 20000) begin
            tick();
            k++;
        end
        check("done_timeout", 32'(k >= 20000), 0);
        tick();
    endtask

    function automatic logic [7:0] wire_byte(input int k);
        logic [7:0] b;
        b = '0;
        for (int j = 0; j < 8; j++) b = {b[6:0], mon_bits[8*k+j]};
        return b;
    endfunction

    // Back-to-back burst of wq[0..n-1] at divider d, then drain RX.
    task automatic run_burst(input int d, input int n);
        int acc, nrx, bad;
        logic [31:0] r;
        acc = (n > 9) ? 9 : n;
        nrx = (acc > 8) ? 8 : acc;
        wr(A_SCKDIV, 32'(d));
        clear_mon();
        wr(A_TX, {24'b0, wq[0]});
        check("cs_before", 32'(spi_csn[0]), 1);
        if (n == 1) tick();
        else wr(A_TX, {24'b0, wq[1]});
        check("cs_fall", 32'(spi_csn[0]), 0);
        check("mosi_b7", 32'(spi_mosi), 32'(wq[0][7]));
        check("sck_low0", 32'(spi_clk), 0);
        for (int i = 2; i < n; i++) wr(A_TX, {24'b0, wq[i]});
        rd(A_TX, r);
        check("tx_full", r, (n >= 9) ? 32'h8000_0000 : 32'h0);
        wait_done(0);
        check("nbits", mon_bits.size(), 8 * acc);
        for (int k = 0; k < acc; k++) begin
            if (mon_bits.size() >= 8 * (k + 1))
                check("wire_byte", wire_byte(k), wq[k]);
        end
        bad = 0;
        foreach (hi_runs[i]) if (hi_runs[i] != d + 1) bad++;
        check("hi_len_bad", bad, 0);
        check("cs_low_cyc", cs0_low, acc * (16 * (d + 1) + 1));
        check("cs1_idle", cs1_low, 0);
        for (int k = 0; k < nrx; k++) begin
            rd(A_RX, r);
            check("rx_data", r,
                  {1'b0, (k == 0 && acc > 8), 22'b0, wq[k]});
        end
        rd(A_RX, r);
        check("rx_empty", r, 32'h8000_0000);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int k;
        reset = 1'b1;
        rq_en = 1'b0;
        rq_addr = '0;
        rq_iswrite = 1'b0;
        rq_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_csn", 32'(spi_csn), 32'h3);
        check("rst_sck", 32'(spi_clk), 0);
        check("rst_mosi", 32'(spi_mosi), 0);
        rd(A_SCKDIV, r); check("rst_sckdiv", r, 0);
        rd(A_RX, r);     check("rst_rx", r, 32'h8000_0000);
        rd(A_TX, r);     check("rst_tx", r, 0);
        rd(A_CSMODE, r); check("rst_csmode", r, 0);

        rq_addr = BASE | 32'h4;
        rq_en = 1'b1;
        #1;
        check("unmapped_hit", {rq_hit, rs_en}, 0);
        rq_addr = BASE | 32'h148;
        #1;
        check("outwin_hit", 32'(rq_hit), 0);
        rq_iswrite = 1'b1;
        rq_data = 32'h5;
        tick();
        rq_en = 1'b0;
        rq_iswrite = 1'b0;
        rd(A_SCKDIV, r); check("outwin_nowr", r, 0);
        rq_addr = BASE | 32'(A_CSMODE);
        rq_iswrite = 1'b1;
        rq_data = 32'h2;
        rq_en = 1'b1;
        #1;
        check("wr_rsdata", {rs_en, rs_data[30:0]}, 32'h8000_0000);
        rq_data = 32'h0;
        tick();
        rq_en = 1'b0;
        rq_iswrite = 1'b0;

        wq = '{8'hA5};
        run_burst(0, 1);

        wq.delete();
        for (int i = 0; i < 10; i++) wq.push_back(8'($urandom));
        run_burst(20, 10);

        wq.delete();
        for (int i = 1; i <= 9; i++) wq.push_back(8'(i));
        run_burst(0, 9);

        for (int it = 0; it < 5; it++) begin
            int d, n;
            d = $urandom_range(0, 3);
            n = $urandom_range(1, 10);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
            run_burst(d, n);
        end

        wr(A_SCKDIV, 3);
        clear_mon();
        wr(A_TX, 32'h3C);
        k = 0;
        while (spi_clk !== 1'b1 && k < 200) begin tick(); k++; end
        check("sck_rise_timeout", 32'(k >= 200), 0);
        wr(A_SCKDIV, 1);
        wait_done(0);
        check("chg_nruns", hi_runs.size(), 8);
        if (hi_runs.size() == 8) begin
            check("chg_hi0", hi_runs[0], 4);
            check("chg_hi1", hi_runs[1], 2);
            check("chg_hi7", hi_runs[7], 2);
        end
        check("chg_cs_cyc", cs0_low, 37);
        rd(A_RX, r); check("chg_rx", r, 32'h3C);

        wr(A_SCKDIV, 0);
        wr(A_CSMODE, 2);
        tick();
        check("hold_idle", 32'(spi_csn), 32'h2);
        clear_mon();
        wr(A_TX, 32'h81);
        wr(A_TX, 32'h7E);
        repeat (45) tick();
        check("hold_high", cs0_high, 0);
        check("hold_bits", mon_bits.size(), 16);
        rd(A_RX, r); check("hold_rx0", r, 32'h81);
        rd(A_RX, r); check("hold_rx1", r, 32'h7E);

        wr(A_CSMODE, 3);
        tick();
        check("off_idle", 32'(spi_csn), 32'h3);
        clear_mon();
        wr(A_TX, 32'hC3);
        repeat (25) tick();
        check("off_low", cs0_low + cs1_low, 0);
        check("off_bits", mon_bits.size(), 8);
        rd(A_RX, r); check("off_rx", r, 32'hC3);

        wr(A_CSMODE, 0);
        wr(A_CSID, 1);
        rd(A_CSID, r); check("csid_rb", r, 1);
        clear_mon();
        wr(A_TX, 32'h96);
        wait_done(1);
        check("csid1_low", cs1_low, 17);
        check("csid1_cs0", cs0_low, 0);
        rd(A_RX, r); check("csid1_rx", r, 32'h96);
        wr(A_CSID, 0);

        wr(A_SCKDIV, 1);
        clear_mon();
        wr(A_TX, 32'h5A);
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        k = 0;
        while (mon_bits.size() < 4 && k < 200) begin tick(); k++; end
        check("bit4_timeout", 32'(k >= 200), 0);
        reset = 1'b1;
        tick();
        check("mid_rst_sck", 32'(spi_clk), 0);
        check("mid_rst_csn", 32'(spi_csn), 32'h3);
        reset = 1'b0;
        tick();
        clear_mon();
        repeat (40) tick();
        check("post_rst_cs", cs0_low, 0);
        check("post_rst_bits", mon_bits.size(), 0);
        rd(A_RX, r);     check("post_rst_rx", r, 32'h8000_0000);
        rd(A_TX, r);     check("post_rst_tx", r, 0);
        rd(A_SCKDIV, r); check("post_rst_div", r, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
